// File: rtl/update_point_pkg.sv
// Shared types and geometry helper for the point-update datapath.
package update_point_pkg;
  localparam int POS_W = 8;
  localparam int VEL_W = 8;

  typedef logic [POS_W-1:0]        pos_t;
  typedef logic signed [VEL_W-1:0] vel_t;

  typedef enum logic [1:0] {IDLE, STEP, CHECK, DONE} state_t;

  // Sign of the cross product (b-a) x (c-a): +1 left turn, -1 right turn, 0 collinear.
  function automatic logic signed [1:0] orient(input longint ax, ay, bx, by, cx, cy);
    longint cr;
    cr = (bx - ax) * (cy - ay) - (by - ay) * (cx - ax);
    if (cr > 0)      return 2'sd1;
    else if (cr < 0) return -2'sd1;
    else             return 2'sd0;
  endfunction
endpackage

// File: rtl/segment_intersect.sv
// Combinational closed-segment intersection test: segment a-b against segment c-d.
module segment_intersect
  import update_point_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] ax,
  input  logic [W-1:0] ay,
  input  logic [W-1:0] bx,
  input  logic [W-1:0] by,
  input  logic [W-1:0] cx,
  input  logic [W-1:0] cy,
  input  logic [W-1:0] dx,
  input  logic [W-1:0] dy,
  output logic         hit
);
  // r lies inside the bounding box of p-q; only meaningful when r is collinear with p-q.
  function automatic logic on_seg(input longint px, py, qx, qy, rx, ry);
    return (rx >= ((px < qx) ? px : qx)) && (rx <= ((px > qx) ? px : qx)) &&
           (ry >= ((py < qy) ? py : qy)) && (ry <= ((py > qy) ? py : qy));
  endfunction

  longint a_x, a_y, b_x, b_y, c_x, c_y, d_x, d_y;
  logic signed [1:0] d1, d2, d3, d4;
  logic proper;

  always_comb begin
    a_x = longint'(ax); a_y = longint'(ay);
    b_x = longint'(bx); b_y = longint'(by);
    c_x = longint'(cx); c_y = longint'(cy);
    d_x = longint'(dx); d_y = longint'(dy);
    d1 = orient(c_x, c_y, d_x, d_y, a_x, a_y);
    d2 = orient(c_x, c_y, d_x, d_y, b_x, b_y);
    d3 = orient(a_x, a_y, b_x, b_y, c_x, c_y);
    d4 = orient(a_x, a_y, b_x, b_y, d_x, d_y);
    proper = (d1 != 0) && (d2 != 0) && (d1 != d2) &&
             (d3 != 0) && (d4 != 0) && (d3 != d4);
    hit = proper ||
          ((d1 == 0) && on_seg(c_x, c_y, d_x, d_y, a_x, a_y)) ||
          ((d2 == 0) && on_seg(c_x, c_y, d_x, d_y, b_x, b_y)) ||
          ((d3 == 0) && on_seg(a_x, a_y, b_x, b_y, c_x, c_y)) ||
          ((d4 == 0) && on_seg(a_x, a_y, b_x, b_y, d_x, d_y));
  end
endmodule

// File: rtl/update_point_unit.sv
// Advances one point by one time step, sweeping obstacle edges one per cycle;
// on any contact the point stays put and the velocity reflects.
module update_point_unit
  import update_point_pkg::*;
#(
  parameter int DT            = 1,
  parameter int POSITION_SIZE = 8,
  parameter int VELOCITY_SIZE = 8,
  parameter int COUNT_SIZE    = 8,
  parameter int MAX_VERTICES  = 4,
  parameter int MAX_OBSTACLES = 1
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic begin_in,
  input  logic [1:0][MAX_VERTICES-1:0][MAX_OBSTACLES-1:0][POSITION_SIZE-1:0] obstacles_in,
  input  logic [MAX_OBSTACLES-1:0][COUNT_SIZE-1:0] num_vertices_in,
  input  logic [COUNT_SIZE-1:0]    num_obstacles_in,
  input  logic [POSITION_SIZE-1:0] pos_x_in,
  input  logic [POSITION_SIZE-1:0] pos_y_in,
  input  logic [VELOCITY_SIZE-1:0] vel_x_in,
  input  logic [VELOCITY_SIZE-1:0] vel_y_in,
  output logic [POSITION_SIZE-1:0] new_pos_x,
  output logic [POSITION_SIZE-1:0] new_pos_y,
  output logic [VELOCITY_SIZE-1:0] new_vel_x,
  output logic [VELOCITY_SIZE-1:0] new_vel_y,
  output logic result_out
);
  localparam int P  = POSITION_SIZE;
  localparam int V  = VELOCITY_SIZE;
  localparam int C  = COUNT_SIZE;
  localparam int CW = P + 2;

  // pos + vel*DT in CW signed bits, clamped into the unsigned position range.
  function automatic logic [P-1:0] advance(input logic [P-1:0] p, input logic [V-1:0] v);
    logic signed [CW-1:0] s;
    s = signed'({2'b00, p}) + CW'(signed'(v)) * CW'(DT);
    if (s[CW-1])              return '0;
    else if (s[CW-2:P] != '0) return '1;
    else                      return s[P-1:0];
  endfunction

  state_t         state;
  logic [P-1:0]   pos_x, pos_y, cand_x, cand_y;
  logic [V-1:0]   vel_x, vel_y;
  logic           hx, hy;
  logic [C-1:0]   o, e;

  logic [C-1:0]   nv, nv_eff, e_nxt, srch, nxt_o;
  logic           last_edge, nxt_found;
  logic [P-1:0]   x0, y0, x1, y1;
  logic           edge_hit, vert, horiz;

  always_comb begin
    nv = '0;
    for (int k = 0; k < MAX_OBSTACLES; k++)
      if (o == C'(k)) nv = num_vertices_in[k];
    nv_eff    = (nv > C'(MAX_VERTICES)) ? C'(MAX_VERTICES) : nv;
    last_edge = (e + C'(1)) >= nv_eff;
    e_nxt     = last_edge ? '0 : e + C'(1);

    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    for (int k = 0; k < MAX_OBSTACLES; k++)
      for (int j = 0; j < MAX_VERTICES; j++)
        if (o == C'(k)) begin
          if (e == C'(j))     begin x0 = obstacles_in[0][j][k]; y0 = obstacles_in[1][j][k]; end
          if (e_nxt == C'(j)) begin x1 = obstacles_in[0][j][k]; y1 = obstacles_in[1][j][k]; end
        end

    // Lowest usable obstacle at or after srch; descending scan leaves the lowest match.
    srch      = (state == CHECK) ? o + C'(1) : '0;
    nxt_found = 1'b0;
    nxt_o     = '0;
    for (int k = MAX_OBSTACLES - 1; k >= 0; k--)
      if ((num_obstacles_in > C'(k)) && (num_vertices_in[k] >= C'(2)) && (C'(k) >= srch)) begin
        nxt_found = 1'b1;
        nxt_o     = C'(k);
      end

    vert  = (x0 == x1);
    horiz = (y0 == y1);
  end

  segment_intersect #(.W(P)) u_seg (
    .ax(pos_x), .ay(pos_y), .bx(cand_x), .by(cand_y),
    .cx(x0),    .cy(y0),    .dx(x1),     .dy(y1),
    .hit(edge_hit)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      pos_x      <= '0; pos_y  <= '0;
      cand_x     <= '0; cand_y <= '0;
      vel_x      <= '0; vel_y  <= '0;
      hx         <= 1'b0; hy <= 1'b0;
      o          <= '0; e <= '0;
      new_pos_x  <= '0; new_pos_y <= '0;
      new_vel_x  <= '0; new_vel_y <= '0;
      result_out <= 1'b0;
    end else begin
      result_out <= 1'b0;
      unique case (state)
        IDLE: if (begin_in) begin
          pos_x <= pos_x_in; pos_y <= pos_y_in;
          vel_x <= vel_x_in; vel_y <= vel_y_in;
          state <= STEP;
        end
        STEP: begin
          cand_x <= advance(pos_x, vel_x);
          cand_y <= advance(pos_y, vel_y);
          hx     <= 1'b0; hy <= 1'b0;
          o      <= nxt_o;
          e      <= '0;
          state  <= nxt_found ? CHECK : DONE;
        end
        CHECK: begin
          if (edge_hit) begin
            if (vert || !horiz) hx <= 1'b1;
            if (horiz || !vert) hy <= 1'b1;
          end
          if (!last_edge) e <= e_nxt;
          else if (nxt_found) begin
            o <= nxt_o;
            e <= '0;
          end else state <= DONE;
        end
        DONE: begin
          result_out <= 1'b1;
          if (hx || hy) begin
            new_pos_x <= pos_x;
            new_pos_y <= pos_y;
            new_vel_x <= hx ? -vel_x : vel_x;
            new_vel_y <= hy ? -vel_y : vel_y;
          end else begin
            new_pos_x <= cand_x;
            new_pos_y <= cand_y;
            new_vel_x <= vel_x;
            new_vel_y <= vel_y;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_update_point_unit.sv
// Scoreboard bench for update_point_unit against a single square obstacle.
module tb_update_point_unit;
  import update_point_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic begin_in = 1'b0;
  logic [1:0][3:0][0:0][7:0] obs;
  logic [0:0][7:0] nverts;
  logic [7:0] nobs;
  pos_t px, py;
  logic [7:0] vx, vy;
  logic [7:0] npx, npy, nvx, nvy;
  logic res;

  always #5 clk = ~clk;

  update_point_unit dut (
    .clk_in(clk), .rst_in(rst), .begin_in(begin_in),
    .obstacles_in(obs), .num_vertices_in(nverts), .num_obstacles_in(nobs),
    .pos_x_in(px), .pos_y_in(py), .vel_x_in(vx), .vel_y_in(vy),
    .new_pos_x(npx), .new_pos_y(npy), .new_vel_x(nvx), .new_vel_y(nvy),
    .result_out(res)
  );

  typedef struct {
    logic [7:0] px, py, vx, vy;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (res) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result at cycle %0d", cyc);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("latency", cyc, x.cyc);
        chk("new_pos_x", npx, x.px);
        chk("new_pos_y", npy, x.py);
        chk("new_vel_x", nvx, x.vx);
        chk("new_vel_y", nvy, x.vy);
      end
    end
  end

  // Pulse begin for one cycle; expected result lands 3+E cycles after the drive edge.
  task automatic issue(input logic [7:0] ipx, ipy, ivx, ivy, inobs, inv, input bit push,
                       input logic [7:0] epx, epy, evx, evy, input int edges);
    @(negedge clk);
    px = ipx; py = ipy; vx = ivx; vy = ivy;
    nobs = inobs; nverts[0] = inv;
    begin_in = 1'b1;
    if (push) sb.push_back('{epx, epy, evx, evy, cyc + 3 + edges});
    @(negedge clk);
    begin_in = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    obs = '0;
    obs[0][1][0] = 8'd0;   obs[1][1][0] = 8'd100;
    obs[0][2][0] = 8'd100; obs[1][2][0] = 8'd100;
    obs[0][3][0] = 8'd100; obs[1][3][0] = 8'd0;
    nverts[0] = 8'd4; nobs = 8'd1;
    px = '0; py = '0; vx = '0; vy = '0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pos_x", npx, 0);
    chk("rst_pos_y", npy, 0);
    chk("rst_vel_x", nvx, 0);
    chk("rst_vel_y", nvy, 0);
    chk("rst_result", res, 0);

    // free move, wall hits, corner, clamping, edge-free runs
    issue(50, 50, 3, 8'hFE, 1, 4, 1, 53, 48, 3, 8'hFE, 4);        drain();
    issue(2, 3, 8'hFE, 0, 1, 4, 1, 2, 3, 2, 0, 4);                drain();
    issue(40, 98, 1, 5, 1, 4, 1, 40, 98, 1, 8'hFB, 4);            drain();
    chk("hold_pos_y", npy, 98);
    chk("hold_vel_y", nvy, 8'hFB);
    issue(50, 50, 3, 8'hFE, 0, 4, 1, 53, 48, 3, 8'hFE, 0);        drain();
    issue(50, 50, 3, 8'hFE, 1, 1, 1, 53, 48, 3, 8'hFE, 0);        drain();
    issue(2, 3, 8'hFB, 0, 1, 4, 1, 2, 3, 5, 0, 4);                drain();
    issue(5, 50, 8'h80, 0, 1, 4, 1, 5, 50, 8'h80, 0, 4);          drain();
    issue(0, 50, 0, 0, 1, 4, 1, 0, 50, 0, 0, 4);                  drain();
    issue(50, 50, 0, 0, 1, 4, 1, 50, 50, 0, 0, 4);                drain();
    issue(200, 200, 100, 0, 1, 4, 1, 255, 200, 100, 0, 4);        drain();
    issue(98, 98, 5, 5, 1, 4, 1, 98, 98, 8'hFB, 8'hFB, 4);        drain();

    // begin re-pulsed while checking edges must be ignored
    issue(50, 50, 3, 8'hFE, 1, 4, 1, 53, 48, 3, 8'hFE, 4);
    @(negedge clk);
    px = 10; py = 10; vx = 1; vy = 1;
    begin_in = 1'b1;
    @(negedge clk);
    begin_in = 1'b0;
    drain();
    repeat (8) @(negedge clk);

    // reset in the middle of CHECK: no result, outputs cleared
    issue(50, 50, 3, 8'hFE, 1, 4, 0, 0, 0, 0, 0, 4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_pos_x", npx, 0);
    chk("abort_pos_y", npy, 0);
    chk("abort_vel_x", nvx, 0);
    chk("abort_vel_y", nvy, 0);
    chk("abort_result", res, 0);

    // unit still works after the abort
    issue(50, 50, 3, 8'hFE, 1, 4, 1, 53, 48, 3, 8'hFE, 4);        drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
